// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and reset constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_UPC   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry hold register catching a fetch response that arrives while IF/ID is stalled.
module fetch_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         vld,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld  <= 1'b0;
      dout <= '0;
    end else begin
      if (clr || pop) vld <= 1'b0;
      else if (push)  vld <= 1'b1;
      if (push) dout <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests feeding the IF/ID slot.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble performance counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_updated_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  fetch_state_e state, state_nxt;
  logic [DATA_W-1:0] pc, pc_inc, redir_aligned;
  logic resp_ok, ld_hold, ld_resp, hold_push, hold_pop, hold_vld;
  logic [2*DATA_W-1:0] hold_dout;

  assign pc_inc        = pc + DATA_W'(PC_STEP);
  assign redir_aligned = redirect_pc & ~DATA_W'(3);
  assign imem_addr     = pc;

  // A response counts only in WAIT and only if no redirect is killing it.
  assign resp_ok   = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign ld_hold   = !redirect_valid && !stall && hold_vld;
  assign ld_resp   = resp_ok && !(stall && id_valid) && !ld_hold;
  assign hold_push = resp_ok && stall && id_valid;
  assign hold_pop  = ld_hold;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_REQ;
      ST_REQ: begin
        if (!enable)       state_nxt = ST_IDLE;
        else if (imem_req) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid)   state_nxt = imem_rvalid ? ST_REQ : ST_KILL;
        else if (imem_rvalid) state_nxt = enable ? ST_REQ : ST_IDLE;
      end
      ST_KILL: begin
        // A redirect coinciding with the stale response still retires it, else KILL would never exit.
        if (redirect_valid)   state_nxt = imem_rvalid ? ST_REQ : ST_KILL;
        else if (imem_rvalid) state_nxt = enable ? ST_REQ : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == ST_REQ) && enable && !hold_vld && !redirect_valid;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc            <= RESET_PC;
      id_valid      <= 1'b0;
      id_instr      <= DATA_W'(RESET_INSTR);
      id_updated_pc <= DATA_W'(RESET_UPC);
    end else if (redirect_valid) begin
      pc       <= redir_aligned;
      id_valid <= 1'b0;
    end else begin
      if (resp_ok) pc <= pc_inc;
      if (ld_hold) begin
        id_valid                  <= 1'b1;
        {id_instr, id_updated_pc} <= hold_dout;
      end else if (ld_resp) begin
        id_valid      <= 1'b1;
        id_instr      <= imem_rdata;
        id_updated_pc <= pc_inc;
      end else if (!stall) begin
        id_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf #(.W(2*DATA_W)) u_hold (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (hold_push),
    .pop    (hold_pop),
    .clr    (redirect_valid),
    .din    ({imem_rdata, pc_inc}),
    .vld    (hold_vld),
    .dout   (hold_dout)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if ((ld_hold || ld_resp) && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (!stall && !id_valid && perf_bubbles != '1)  perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with directed reset/redirect/stall/wrap scenarios.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        arst_n, enable, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr, id_updated_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  fetch_unit #(.DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_updated_pc(id_updated_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int fix_lat = 1;
  logic [63:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: one request at a time, fixed or random 1..3 cycle latency.
  initial begin
    logic        busy = 1'b0;
    int          lat = 0;
    logic [31:0] maddr = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && arst_n) begin
        if (busy) chk("one_outstanding", 32'd1, 32'd0);
        busy  = 1'b1;
        lat   = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 3));
        maddr = imem_addr;
      end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (busy) begin
        lat--;
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(maddr);
          busy        = 1'b0;
        end
      end
    end
  end

  // Monitor: expected IF/ID words are the sequential fetch stream, flushed by redirect or reset.
  initial begin
    logic [31:0] exp_pc = RST_PC;
    logic        prev_hold = 1'b0;
    logic [31:0] p_instr = '0, p_upc = '0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        sb.delete();
        exp_pc    = RST_PC;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("stall_hold_valid", {31'd0, id_valid}, 32'd1);
          chk("stall_hold_instr", id_instr, p_instr);
          chk("stall_hold_upc", id_updated_pc, p_upc);
        end
        if (redirect_valid) begin
          sb.delete();
          exp_pc = redirect_pc & ~32'd3;
        end else begin
          if (id_valid && !stall) begin
            if (sb.size() == 0) chk("unexpected_id_word", id_instr, 32'hDEAD_DEAD);
            else begin
              e = sb.pop_front();
              chk("id_instr", id_instr, e[63:32]);
              chk("id_updated_pc", id_updated_pc, e[31:0]);
            end
          end
          if (imem_req) begin
            chk("imem_addr", imem_addr, exp_pc);
            sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
            exp_pc = exp_pc + 32'd4;
          end
        end
        prev_hold = stall && !redirect_valid && id_valid;
        p_instr   = id_instr;
        p_upc     = id_updated_pc;
      end
    end
  end

  task automatic wait_req(output logic [31:0] a);
    a = 32'hXXXX_XXXX;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req) begin
        a = imem_addr;
        return;
      end
    end
    chk("wait_req_timeout", 32'd1, 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    arst_n = 1'b0; enable = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_upc", id_updated_pc, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    repeat (2) cyc();
    arst_n = 1'b1;
    cyc();

    // Basic fetch with 1-cycle memory.
    fix_lat = 1; enable = 1'b1;
    wait_req(a); chk("first_addr", a, 32'h0);
    wait_req(a); chk("second_addr", a, 32'h4);
    chk("first_valid", {31'd0, id_valid}, 32'd1);
    chk("first_instr", id_instr, 32'h2008_0005);
    chk("first_upc", id_updated_pc, 32'h4);

    // Redirect coinciding with rvalid: response dropped.
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    cyc();
    redirect_valid = 1'b0;
    fix_lat = 2;
    wait_req(a); chk("redir_rvalid_addr", a, 32'h40);

    // Redirect in WAIT, stale response the following cycle.
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk); chk("kill_bubble", {31'd0, id_valid}, 32'd0);
    fix_lat = 1;
    wait_req(a); chk("redir_wait_addr", a, 32'h40);
    chk("kill_no_stale", {31'd0, id_valid}, 32'd0);

    // Stall across a response: hold buffer absorbs it.
    cyc();
    stall = 1'b1;
    repeat (4) cyc();
    stall = 1'b0;
    repeat (6) cyc();

    // PC wraps modulo 2^32.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    cyc();
    redirect_valid = 1'b0;
    wait_req(a); chk("wrap_first", a, 32'hFFFF_FFFC);
    wait_req(a); chk("wrap_second", a, 32'h0);

    // Asynchronous reset during WAIT, late response after release.
    cyc();
    fix_lat = 3;
    wait_req(a);
    cyc();
    arst_n = 1'b0; enable = 1'b0;
    #1;
    chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_id_instr", id_instr, 32'd0);
    chk("arst_id_upc", id_updated_pc, 32'd0);
    chk("arst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("arst_imem_addr", imem_addr, RST_PC);
    cyc();
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_rvalid_ignored", {31'd0, id_valid}, 32'd0);
    end
    cyc();

    // Randomized run.
    fix_lat = 0; enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : ($urandom & 32'h0000_FFFF);
      enable         = ($urandom_range(0, 99) < 90);
    end

    // Drain: every fetched word must reach ID exactly once.
    cyc();
    stall = 1'b0; redirect_valid = 1'b0; enable = 1'b0;
    repeat (20) cyc();
    chk("drain_empty", sb.size(), 32'd0);
    chk("drain_idle", {31'd0, id_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
